// File: rtl/matrix_key_scanner.sv
// 4x4 keypad scanner: row drive, 2-FF column synchroniser, frame-level debounce, press pulses.
// Optional macro MATRIX_KEY_SINGLE_EN: suppress key_pulse whenever more than one key is down.
module matrix_key_scanner #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DB_SCANS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] key_state,
    output logic [15:0] key_pulse
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned SW = $clog2(DB_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(DB_SCANS);
    localparam logic [SW-1:0] STABLE_LAST = SW'(DB_SCANS - 1);

    typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_e;

    logic [3:0]    col_meta, col_sync;
    logic [DW-1:0] dwell, dwell_nxt;
    row_e          row_idx, row_idx_nxt;
    logic [15:0]   raw, raw_nxt;
    logic [15:0]   prev_raw, prev_raw_nxt;
    logic [SW-1:0] stable_cnt, stable_nxt;
    logic [15:0]   key_state_nxt, key_pulse_nxt;

    // Idle columns read high, so the synchroniser resets to "no key".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    always_comb begin
        dwell_nxt     = dwell + 1'b1;
        row_idx_nxt   = row_idx;
        raw_nxt       = raw;
        prev_raw_nxt  = prev_raw;
        stable_nxt    = stable_cnt;
        key_state_nxt = key_state;
        key_pulse_nxt = '0;

        if (dwell == DWELL_LAST) begin
            dwell_nxt   = '0;
            row_idx_nxt = row_e'(row_idx + 2'd1);
            raw_nxt[{row_idx, 2'b00} +: 4] = ~col_sync;

            // Frame end: raw_nxt already holds the freshly merged row-3 nibble.
            if (row_idx == ROW3) begin
                prev_raw_nxt = raw_nxt;
                if (raw_nxt == prev_raw) begin
                    if (stable_cnt < STABLE_MAX)
                        stable_nxt = stable_cnt + 1'b1;
                    if (stable_cnt == STABLE_LAST)
                        key_state_nxt = raw_nxt;
                end else begin
                    stable_nxt = '0;
                end
            end
        end

        key_pulse_nxt = key_state_nxt & ~key_state;
`ifdef MATRIX_KEY_SINGLE_EN
        if ((key_state_nxt & (key_state_nxt - 16'd1)) != '0)
            key_pulse_nxt = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell      <= '0;
            row_idx    <= ROW0;
            raw        <= '0;
            prev_raw   <= '0;
            stable_cnt <= '0;
            key_state  <= '0;
            key_pulse  <= '0;
        end else begin
            dwell      <= dwell_nxt;
            row_idx    <= row_idx_nxt;
            raw        <= raw_nxt;
            prev_raw   <= prev_raw_nxt;
            stable_cnt <= stable_nxt;
            key_state  <= key_state_nxt;
            key_pulse  <= key_pulse_nxt;
        end
    end

    always_comb row = ~(4'b0001 << row_idx);

endmodule
